// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Purpose
//   Load-use hazard detection and pipeline stall/flush control for a classic
//   five-stage in-order pipeline. The block decides each cycle whether the
//   front end runs, stalls behind a load, is redirected by a taken branch, or
//   is frozen by a busy data memory. The priority order is
//   FREEZE > REDIRECT > STALL > NORMAL.
//
//   A load-use stall lasts LOAD_LAT non-frozen cycles. The first stall cycle
//   is taken in RUN. Any further cycles are counted down in LSTALL with a
//   3-bit remaining-cycle counter.
//
// Parameters
//   REG_ADDR_W : register-address width
//   LOAD_LAT   : load-use stall length in cycles (legal 1..7)
//   PERF_W     : stall-counter width (only used with HAZARD_PERF_CNT_EN)
//
// Ports
//   clk            in   single clock, rising-edge
//   rst            in   synchronous active-high reset
//   ID_EX_MemR     in   EX instruction is a load
//   ID_EX_RegRd    in   EX destination register
//   IF_ID_RegRs1/2 in   ID source registers
//   IF_ID_UseRs1/2 in   ID instruction really reads that source
//   EX_Redirect    in   taken branch / jump resolved in EX
//   Mem_Busy       in   data memory not ready, whole pipeline freezes
//   block_control  out  force a bubble (control zeroed) into ID/EX
//   PC_Write       out  PC update enable
//   IF_ID_Write    out  IF/ID register update enable
//   ID_EX_Write    out  ID/EX register update enable
//   IF_ID_Flush    out  squash the IF/ID instruction
//   stall_active   out  high in STALL and FREEZE cycles
//   stall_cnt      out  total stall cycles (only with HAZARD_PERF_CNT_EN)
//
// Configuration macro
//   HAZARD_PERF_CNT_EN : when defined, adds the stall_cnt port and counter.
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ID_EX_MemR,
    input  logic [REG_ADDR_W-1:0] ID_EX_RegRd,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegRs1,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegRs2,
    input  logic                  IF_ID_UseRs1,
    input  logic                  IF_ID_UseRs2,
    input  logic                  EX_Redirect,
    input  logic                  Mem_Busy,
    output logic                  block_control,
    output logic                  PC_Write,
    output logic                  IF_ID_Write,
    output logic                  ID_EX_Write,
    output logic                  IF_ID_Flush,
    output logic                  stall_active
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]     stall_cnt
`endif
);

    // An out-of-range configuration degrades to a single-cycle stall rather
    // than loading a wrapped value into the 3-bit counter.
    localparam logic       PARAMS_OK = (LOAD_LAT >= 1) && (LOAD_LAT <= 7) && (PERF_W >= 1);
    localparam logic [2:0] REM_INIT  = PARAMS_OK ? 3'(LOAD_LAT - 1) : 3'd0;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_LSTALL = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] rem_q, rem_d;
    logic       hazard_s;

    // Load-use hazard: x0 is hard-wired to zero, so it never creates a dependency.
    assign hazard_s = ID_EX_MemR
                   && (ID_EX_RegRd != {REG_ADDR_W{1'b0}})
                   && ((IF_ID_UseRs1 && (IF_ID_RegRs1 == ID_EX_RegRd))
                    || (IF_ID_UseRs2 && (IF_ID_RegRs2 == ID_EX_RegRd)));

    // Output decode and next-state logic, priority FREEZE > REDIRECT > STALL > NORMAL.
    always_comb begin
        block_control = 1'b0;
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        stall_active  = 1'b0;
        state_d       = state_q;
        rem_d         = rem_q;

        if (rst) begin
            // NORMAL outputs while reset is held; the register block clears state.
            state_d = ST_RUN;
            rem_d   = 3'd0;
        end else if (Mem_Busy) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            stall_active = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (EX_Redirect) begin
                        // The flush kills the dependent instruction, so no stall.
                        block_control = 1'b1;
                        IF_ID_Flush   = 1'b1;
                    end else if (hazard_s) begin
                        block_control = 1'b1;
                        PC_Write      = 1'b0;
                        IF_ID_Write   = 1'b0;
                        stall_active  = 1'b1;
                        if (REM_INIT != 3'd0) begin
                            state_d = ST_LSTALL;
                            rem_d   = REM_INIT;
                        end else begin
                            state_d = ST_RUN;
                            rem_d   = 3'd0;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_LSTALL: begin
                    // EX holds a bubble here, so EX_Redirect cannot be genuine.
                    block_control = 1'b1;
                    PC_Write      = 1'b0;
                    IF_ID_Write   = 1'b0;
                    stall_active  = 1'b1;
                    if (rem_q <= 3'd1) begin
                        // Also exits cleanly if rem was somehow corrupted to 0.
                        state_d = ST_RUN;
                        rem_d   = 3'd0;
                    end else begin
                        state_d = ST_LSTALL;
                        rem_d   = rem_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    rem_d   = 3'd0;
                end
            endcase
        end
    end

    // State and remaining-cycle registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            rem_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    // Stall-cycle counter increment, wrapping naturally at 2^PERF_W.
    always_comb begin
        if (stall_active) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall-cycle counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= {PERF_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, legal range 1..7, number of load-use stall cycles.
REQ-003 SHALL have parameter PERF_W, default 32, stall-counter width (used only under HAZARD_PERF_CNT_EN).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port ID_EX_MemR  input  1  instruction in EX is a load.
REQ-007 SHALL have port ID_EX_RegRd  input  REG_ADDR_W  destination register of the EX instruction.
REQ-008 SHALL have ports IF_ID_RegRs1, IF_ID_RegRs2  input  REG_ADDR_W  source registers of the ID instruction.
REQ-009 SHALL have ports IF_ID_UseRs1, IF_ID_UseRs2  input  1  the ID instruction actually reads that source.
REQ-010 SHALL have port EX_Redirect  input  1  taken branch or jump resolved in EX.
REQ-011 SHALL have port Mem_Busy  input  1  data memory not ready; whole pipeline freezes.
REQ-012 SHALL have outputs block_control, PC_Write, IF_ID_Write, ID_EX_Write, IF_ID_Flush, stall_active  output  1 each.
REQ-013 SHALL have port stall_cnt  output  PERF_W  total stall cycles; present only under HAZARD_PERF_CNT_EN.

Function
REQ-014 hazard SHALL be ID_EX_MemR && ID_EX_RegRd!=0 && ((UseRs1 && Rs1==RegRd) || (UseRs2 && Rs2==RegRd)).
REQ-015 FSM SHALL have states RUN and LSTALL, plus a 3-bit remaining-cycle counter rem.
REQ-016 Outputs SHALL be combinational from state and current inputs (zero-cycle detection latency), in priority order FREEZE > REDIRECT > STALL > NORMAL.
REQ-017 FREEZE (Mem_Busy=1, any state): block_control=0, PC_Write=0, IF_ID_Write=0, ID_EX_Write=0, IF_ID_Flush=0; state, rem and stall_cnt held.
REQ-018 REDIRECT (Mem_Busy=0, EX_Redirect=1, state RUN): block_control=1, PC_Write=1, IF_ID_Write=1, ID_EX_Write=1, IF_ID_Flush=1; stays RUN even if hazard is true.
REQ-019 STALL (state RUN with hazard, or state LSTALL): block_control=1, PC_Write=0, IF_ID_Write=0, ID_EX_Write=1 (bubble written into ID/EX), IF_ID_Flush=0.
REQ-020 NORMAL: block_control=0, PC_Write=1, IF_ID_Write=1, ID_EX_Write=1, IF_ID_Flush=0.
REQ-021 stall_active SHALL equal 1 exactly in STALL and FREEZE cycles.
REQ-022 RUN + STALL with LOAD_LAT=1 SHALL remain RUN; with LOAD_LAT>1 SHALL go to LSTALL, rem=LOAD_LAT-1.
REQ-023 In LSTALL each non-frozen cycle SHALL decrement rem; rem==1 in that cycle SHALL return to RUN next edge.
REQ-024 EX_Redirect in LSTALL SHALL be ignored (EX holds a bubble) and SHALL not alter the count.
REQ-025 A load-use stall SHALL therefore hold PC and IF/ID for exactly LOAD_LAT non-frozen cycles.
REQ-026 Mem_Busy mid-stall SHALL extend the stall by the frozen cycles without consuming rem.

Reset
REQ-027 rst=1 at a rising edge SHALL set state=RUN, rem=0, stall_cnt=0.
REQ-028 While rst=1 outputs SHALL show NORMAL values (0,1,1,1,0), stall_active=0, regardless of other inputs.
REQ-029 Reset asserted in LSTALL SHALL abort the stall; first cycle after release is RUN.

Configuration
REQ-030 Macro HAZARD_PERF_CNT_EN defined: stall_cnt SHALL increment by 1 each non-reset cycle with stall_active=1, wrapping modulo 2^PERF_W.
REQ-031 Macro undefined: stall_cnt port and its register SHALL not exist; all other behaviour identical.

Verification
REQ-032 LOAD_LAT=1, MemR=1, RegRd=5, Rs1=5, UseRs1=1 -> one cycle of 1,0,0,1,0; next cycle NORMAL.
REQ-033 LOAD_LAT=3, same hazard held -> exactly 3 STALL cycles, then NORMAL; stall_cnt=3.
REQ-034 MemR=1, RegRd=0, Rs1=0, UseRs1=1 -> NORMAL (x0 never stalls); Rs2 match with UseRs2=0 -> NORMAL.
REQ-035 Hazard and EX_Redirect same cycle in RUN -> REDIRECT outputs (Flush=1), stall_cnt unchanged.
REQ-036 LOAD_LAT=3, Mem_Busy=1 for 2 cycles during the 2nd stall cycle -> 5 stall_active cycles total, PC_Write=0 throughout, stall_cnt=5.
REQ-037 rst pulsed during LSTALL -> next cycle NORMAL, stall_cnt=0.
